load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: the pipeline MEM stage hands load/store requests to this unit.
- It sequences Mem_address/Mem_read/Mem_write/Write_data toward the word-addressed data memory and captures Read_Data.
- It converts byte addresses to word indices and performs sub-word extraction (lb/lbu/lh/lhu).
- Sub-word stores (sb/sh) use read-modify-write. The unit stalls the pipeline via req_ready until each access completes.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/load_store_unit_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD,
        MERGE,
        WR,
        RESP
    } lsu_state_t;

    // Reserved size 3 is reported as misaligned so it takes the error path.
    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~lane[0];
            SZ_WORD: return lane == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences load/store requests onto a word-addressed data memory; all outputs registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 10,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] Mem_address,
    output logic        Mem_read,
    output logic        Mem_write,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_Data
);

    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    lsu_state_t state, next_state;

    logic          is_store_q, uns_q;
    logic [1:0]    size_q, lane_q;
    logic [31:0]   wdata_q, word_q;
    logic [CW-1:0] rd_cnt;
    logic          rd_done, accept, acc_err;
    logic [31:0]   align_word, load_data, store_word;

    logic          req_ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
    logic [31:0]   resp_rdata_d, mem_address_d, write_data_d;

    assign accept  = req_valid & req_ready;
    assign acc_err = ~size_aligned(req_size, req_addr[1:0])
                   | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    assign rd_done = (rd_cnt == CW'(RD_LAT - 1));

    // Loads extract straight from the bus on the last RD edge; merges use the captured word.
    assign align_word = (state == RD) ? Read_Data : word_q;

    lsu_lane_align u_align (
        .word        (align_word),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = acc_err ? RESP : SETUP;
            SETUP:   next_state = (is_store_q && size_q == SZ_WORD) ? WR : RD;
            RD:      if (rd_done) next_state = is_store_q ? MERGE : RESP;
            MERGE:   next_state = WR;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so the registered strobes line up with the state.
    always_comb begin
        req_ready_d   = (next_state == IDLE);
        resp_valid_d  = (next_state == RESP);
        resp_err_d    = (next_state == RESP) && (state == IDLE);
        mem_read_d    = (next_state == RD);
        mem_write_d   = (next_state == WR);
        mem_address_d = (accept && !acc_err) ? {2'b00, req_addr[31:2]} : Mem_address;
        resp_rdata_d  = resp_rdata;
        if (next_state == RESP) resp_rdata_d = (state == RD) ? load_data : '0;
        write_data_d  = Write_data;
        if (next_state == WR) write_data_d = (state == MERGE) ? store_word : wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            Mem_read    <= 1'b0;
            Mem_write   <= 1'b0;
            Mem_address <= '0;
            Write_data  <= '0;
            is_store_q  <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            lane_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            rd_cnt      <= '0;
        end else begin
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_err    <= resp_err_d;
            resp_rdata  <= resp_rdata_d;
            Mem_read    <= mem_read_d;
            Mem_write   <= mem_write_d;
            Mem_address <= mem_address_d;
            Write_data  <= write_data_d;
            if (accept) begin
                is_store_q <= req_is_store;
                uns_q      <= req_unsigned;
                size_q     <= req_size;
                lane_q     <= req_addr[1:0];
                wdata_q    <= req_wdata;
            end
            if (state == RD && rd_done) word_q <= Read_Data;
            rd_cnt <= (state == RD) ? rd_cnt + CW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small negedge-commit memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] Mem_address, Write_data, Read_Data;
    logic        Mem_read, Mem_write;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [10] = '{32'd4, 32'd2, 32'd3, 32'd5, 32'd7, 32'd8, 32'd9, 32'd0, 32'd1, 32'd4};
    int          rd_cyc = 0, rd_rise = 0, wr_cyc = 0, wr_rise = 0;
    logic [31:0] wa_last = '0, wd_last = '0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(10), .RD_LAT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .Mem_address  (Mem_address),
        .Mem_read     (Mem_read),
        .Mem_write    (Mem_write),
        .Write_data   (Write_data),
        .Read_Data    (Read_Data)
    );

    // Memory refreshes Read_Data only on a rising Mem_read and commits writes on negedge.
    always @(posedge Mem_read) begin
        rd_rise++;
        Read_Data <= mem[Mem_address];
    end
    always @(posedge Mem_write) wr_rise++;
    always @(negedge clk) begin
        if (Mem_read) rd_cyc++;
        if (Mem_write) begin
            wr_cyc++;
            mem[Mem_address] <= Write_data;
            wa_last <= Mem_address;
            wd_last <= Write_data;
        end
    end

    typedef struct {
        string       name;
        logic        st;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic st, logic [1:0] sz, logic un, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] er, logic ee, int lat, int rd,
                                int wr, logic [31:0] wa, logic [31:0] wd);
        vec_t v;
        v.name = n; v.st = st; v.sz = sz; v.un = un; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee; v.lat = lat; v.rd = rd; v.wr = wr; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat, rd0, rr0, wr0, wrr0;
        wait_ready(v.name);
        rd0 = rd_cyc; rr0 = rd_rise; wr0 = wr_cyc; wrr0 = wr_rise;
        req_is_store = v.st; req_size = v.sz; req_unsigned = v.un;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, "_rdata"}, resp_rdata, v.exp_rdata);
        chk({v.name, "_err"}, 32'(resp_err), 32'(v.exp_err));
        chk({v.name, "_rd_cycles"}, 32'(rd_cyc - rd0), 32'(v.rd));
        chk({v.name, "_rd_rises"}, 32'(rd_rise - rr0), 32'(v.rd));
        chk({v.name, "_wr_cycles"}, 32'(wr_cyc - wr0), 32'(v.wr));
        chk({v.name, "_wr_rises"}, 32'(wr_rise - wrr0), 32'(v.wr));
        if (v.wr != 0) begin
            chk({v.name, "_wr_addr"}, wa_last, v.wa);
            chk({v.name, "_wr_data"}, wd_last, v.wd);
        end
        @(posedge clk); #1;
        chk({v.name, "_resp_one_cycle"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int wr0, wrr0, acc, resp_n, last_acc, cyc;
        logic rdy_before;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp [3];

        reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_strobes", {30'd0, Mem_read, Mem_write}, 32'd0);
        chk("rst_mem_address", Mem_address, 32'd0);
        chk("rst_write_data", Write_data, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        //                name       st    sz    un    addr   wdata         rdata         err lat rd wr wa     wd
        vecs.push_back(mk("lw12",    1'b0, 2'd2, 1'b0, 32'd12, 32'd0,       32'd5,        0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("sb5",     1'b1, 2'd0, 1'b0, 32'd5,  32'hAB,      32'd0,        0, 5, 1, 1, 32'd1, 32'h0000AB02));
        vecs.push_back(mk("lw4",     1'b0, 2'd2, 1'b0, 32'd4,  32'd0,       32'h0000AB02, 0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("sb16",    1'b1, 2'd0, 1'b0, 32'd16, 32'h80,      32'd0,        0, 5, 1, 1, 32'd4, 32'h00000080));
        vecs.push_back(mk("lb16",    1'b0, 2'd0, 1'b0, 32'd16, 32'd0,       32'hFFFFFF80, 0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("lbu16",   1'b0, 2'd0, 1'b1, 32'd16, 32'd0,       32'h00000080, 0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("lw6_err", 1'b0, 2'd2, 1'b0, 32'd6,  32'd0,       32'd0,        1, 1, 0, 0, 0,     0));
        vecs.push_back(mk("lh3_err", 1'b0, 2'd1, 1'b0, 32'd3,  32'd0,       32'd0,        1, 1, 0, 0, 0,     0));
        vecs.push_back(mk("lw40_err",1'b0, 2'd2, 1'b0, 32'd40, 32'd0,       32'd0,        1, 1, 0, 0, 0,     0));
        vecs.push_back(mk("sz3_err", 1'b0, 2'd3, 1'b0, 32'd0,  32'd0,       32'd0,        1, 1, 0, 0, 0,     0));
        vecs.push_back(mk("sw36",    1'b1, 2'd2, 1'b0, 32'd36, 32'h12345678,32'd0,        0, 3, 0, 1, 32'd9, 32'h12345678));
        vecs.push_back(mk("lh38",    1'b0, 2'd1, 1'b0, 32'd38, 32'd0,       32'h00001234, 0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("lb39",    1'b0, 2'd0, 1'b0, 32'd39, 32'd0,       32'h00000012, 0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("sh26",    1'b1, 2'd1, 1'b0, 32'd26, 32'h8001,    32'd0,        0, 5, 1, 1, 32'd6, 32'h80010009));
        vecs.push_back(mk("lh26",    1'b0, 2'd1, 1'b0, 32'd26, 32'd0,       32'hFFFF8001, 0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("lhu26",   1'b0, 2'd1, 1'b1, 32'd26, 32'd0,       32'h00008001, 0, 3, 1, 0, 0,     0));
        vecs.push_back(mk("lb5",     1'b0, 2'd0, 1'b0, 32'd5,  32'd0,       32'hFFFFFFAB, 0, 3, 1, 0, 0,     0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted while the sh sits in MERGE: no write may follow.
        wait_ready("sh8");
        wr0 = wr_cyc; wrr0 = wr_rise;
        req_is_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'd8; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk); #1;            // SETUP
        req_valid = 1'b0;
        @(posedge clk); #1;            // RD
        chk("sh8_rd_strobe", 32'(Mem_read), 32'd1);
        @(posedge clk); #1;            // MERGE
        chk("sh8_merge_no_read", 32'(Mem_read), 32'd0);
        reset = 1'b0;
        #1;
        chk("sh8_rst_strobes", {30'd0, Mem_read, Mem_write}, 32'd0);
        chk("sh8_rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("sh8_no_wr_cycles", 32'(wr_cyc - wr0), 32'd0);
        chk("sh8_no_wr_rise", 32'(wr_rise - wrr0), 32'd0);
        chk("sh8_word2_kept", mem[2], 32'd3);
        chk("sh8_no_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("sh8_ready_after_release", 32'(req_ready), 32'd1);
        chk("sh8_still_no_resp", 32'(resp_valid), 32'd0);

        // Three loads with req_valid held high the whole time.
        b2b_addr[0] = 32'd0; b2b_exp[0] = 32'd4;
        b2b_addr[1] = 32'd4; b2b_exp[1] = 32'h0000AB02;
        b2b_addr[2] = 32'd8; b2b_exp[2] = 32'd3;
        acc = 0; resp_n = 0; last_acc = -1; cyc = 0;
        req_is_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        while (resp_n < 3 && cyc < 60) begin
            @(negedge clk);
            if (acc < 3) begin
                req_addr = b2b_addr[acc];
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            rdy_before = req_ready;
            @(posedge clk);
            if (rdy_before && req_valid) begin
                if (last_acc >= 0) chk("b2b_accept_gap", 32'(cyc - last_acc), 32'd4);
                last_acc = cyc;
                acc++;
            end
            #1;
            if (acc > resp_n && acc <= 3 && (cyc != last_acc))
                chk("b2b_ready_low_busy", 32'(req_ready && !resp_valid && (acc == resp_n)), 32'd0);
            if (resp_valid) begin
                if (resp_n < 3) chk("b2b_rdata", resp_rdata, b2b_exp[resp_n]);
                resp_n++;
            end
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_responses", 32'(resp_n), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
